lane_deserializer: RTL

- Sits directly downstream of the 1-to-2 bit decoder.
- Consumes the decoder's two output lanes plus the select that steered them.
- Accumulates each lane's serial bits into WIDTH-bit words, LSB first.
- Presents completed words on one valid/ready output port, with round-robin arbitration between lanes and per-lane sticky overflow flags.

---
 rtl/lane_deserializer_if.sv | 26 ++
 rtl/lane_deserializer.sv | 80 ++++++++
 2 files changed

// File: rtl/lane_deserializer_if.sv
// Signal bundle between the 1-to-2 decoder side and the word consumer of lane_deserializer.
// Latency: none (wires only).
// Backpressure: byte_ready stalls the word side; the bit side has no backpressure.
interface lane_deserializer_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       lane_in;
    logic             lane_sel;
    logic             bit_valid;
    logic [WIDTH-1:0] byte_out;
    logic             byte_lane;
    logic             byte_valid;
    logic             byte_ready;
    logic [1:0]       overflow;
    logic             ovf_clr;

    modport master (
        output lane_in, lane_sel, bit_valid, byte_ready, ovf_clr,
        input  byte_out, byte_lane, byte_valid, overflow
    );

    modport slave (
        input  lane_in, lane_sel, bit_valid, byte_ready, ovf_clr,
        output byte_out, byte_lane, byte_valid, overflow
    );
endinterface

// File: rtl/lane_deserializer.sv
// Assembles two decoder lanes into WIDTH-bit words (LSB first), round-robin onto one output port.
// Latency: word valid 1 cycle after its last bit (2 if the arbiter must switch lanes first).
// Backpressure: byte_ready stalls output; a lane completing a word while still full drops it and flags overflow.
module lane_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    lane_deserializer_if.slave  bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh   [2];
    logic [CW-1:0]    cnt  [2];
    logic [WIDTH-1:0] hold [2];
    logic [WIDTH-1:0] word [2];
    logic [1:0]       full;
    logic [1:0]       ovf;
    logic [1:0]       acc;
    logic [1:0]       done;
    logic [1:0]       xfer_k;
    logic [1:0]       load;
    logic             cur;
    logic             xfer;
    logic             cur_tgl;

    always_comb begin
        xfer    = full[cur] && bus.byte_ready;
        cur_tgl = xfer || (!full[cur] && full[~cur]);
        for (int k = 0; k < 2; k++) begin
            acc[k]    = bus.bit_valid && (bus.lane_sel == k[0]);
            done[k]   = acc[k] && (cnt[k] == LAST);
            word[k]   = {bus.lane_in[k], sh[k][WIDTH-1:1]};
            xfer_k[k] = xfer && (cur == k[0]);
            // A held word may be replaced only if it is leaving this very cycle.
            load[k]   = done[k] && (!full[k] || xfer_k[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                sh[k]   <= '0;
                cnt[k]  <= '0;
                hold[k] <= '0;
            end
            full <= '0;
            ovf  <= '0;
            cur  <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (acc[k]) begin
                    sh[k]  <= word[k];
                    cnt[k] <= done[k] ? '0 : cnt[k] + 1'b1;
                end
                if (load[k]) begin
                    hold[k] <= word[k];
                    full[k] <= 1'b1;
                end else if (xfer_k[k]) begin
                    full[k] <= 1'b0;
                end
                // Set beats clear when both land in the same cycle.
                if (done[k] && !load[k]) begin
                    ovf[k] <= 1'b1;
                end else if (bus.ovf_clr) begin
                    ovf[k] <= 1'b0;
                end
            end
            if (cur_tgl) begin
                cur <= ~cur;
            end
        end
    end

    assign bus.byte_out   = hold[cur];
    assign bus.byte_lane  = cur;
    assign bus.byte_valid = full[cur];
    assign bus.overflow   = ovf;
endmodule
